// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for sobel_calc: raster-scans the input frame, gathers each
// interior 3x3 window, and writes the magnitude (0 on borders/timeouts) out.
module sobel_frame_ctrl #(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              err_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [7:0]        rd_data_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic [7:0]        d0_o,
    output logic [7:0]        d1_o,
    output logic [7:0]        d2_o,
    output logic [7:0]        d3_o,
    output logic [7:0]        d4_o,
    output logic [7:0]        d5_o,
    output logic [7:0]        d6_o,
    output logic [7:0]        d7_o,
    output logic [7:0]        d8_o,
    output logic              calc_start_o,
    input  logic [7:0]        calc_gray_i,
    input  logic              calc_done_i
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] ROW = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_n;
    logic [YW-1:0]     y_q, y_n;
    logic [ADDR_W-1:0] pix_q, tap_a;
    logic [3:0]        k_q;
    logic [CW-1:0]     cnt_q;
    logic [7:0]        win_q [9];
    logic [7:0]        res_q;
    logic              err_q;
    logic              last_x, last_y, last_px, next_border, timeout;

    always_comb begin
        last_x      = (x_q == XW'(IMG_W - 1));
        last_y      = (y_q == YW'(IMG_H - 1));
        last_px     = last_x && last_y;
        x_n         = last_x ? '0 : x_q + XW'(1);
        y_n         = last_x ? y_q + YW'(1) : y_q;
        next_border = (x_n == '0) || (y_n == '0) ||
                      (x_n == XW'(IMG_W - 1)) || (y_n == YW'(IMG_H - 1));
        timeout     = (cnt_q == CW'(TIMEOUT));
    end

    // Tap k of the window around pix_q, row-major from the upper-left corner.
    always_comb begin
        case (k_q)
            4'd0:    tap_a = pix_q - ROW - ONE;
            4'd1:    tap_a = pix_q - ROW;
            4'd2:    tap_a = pix_q - ROW + ONE;
            4'd3:    tap_a = pix_q - ONE;
            4'd4:    tap_a = pix_q;
            4'd5:    tap_a = pix_q + ONE;
            4'd6:    tap_a = pix_q + ROW - ONE;
            4'd7:    tap_a = pix_q + ROW;
            4'd8:    tap_a = pix_q + ROW + ONE;
            default: tap_a = pix_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_WRITE;
            S_FETCH: if (k_q == 4'd9) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (calc_done_i || timeout) state_d = S_WRITE;
            S_WRITE: begin
                if (last_px)          state_d = S_DONE;
                else if (next_border) state_d = S_WRITE;
                else                  state_d = S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        frame_done_o = 1'b0;
        rd_en_o      = 1'b0;
        rd_addr_o    = '0;
        wr_en_o      = 1'b0;
        wr_addr_o    = '0;
        wr_data_o    = '0;
        calc_start_o = 1'b0;
        busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
        case (state_q)
            S_FETCH: begin
                if (k_q != 4'd9) begin
                    rd_en_o   = 1'b1;
                    rd_addr_o = tap_a;
                end
            end
            S_ISSUE: calc_start_o = 1'b1;
            S_WRITE: begin
                wr_en_o   = 1'b1;
                wr_addr_o = pix_q;
                wr_data_o = res_q;
            end
            S_DONE:  frame_done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            pix_q <= '0;
            k_q   <= '0;
            cnt_q <= '0;
            res_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            k_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        x_q   <= '0;
                        y_q   <= '0;
                        pix_q <= '0;
                        res_q <= '0;
                        err_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    k_q <= k_q + 4'd1;
                    for (int i = 0; i < 9; i++)
                        if (k_q == 4'(i + 1)) win_q[i] <= rd_data_i;
                end
                S_ISSUE: cnt_q <= CW'(1);
                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (calc_done_i) begin
                        res_q <= calc_gray_i;
                    end else if (timeout) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    x_q   <= x_n;
                    y_q   <= y_n;
                    pix_q <= pix_q + ONE;
                    res_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign err_o = err_q;
    assign d0_o  = win_q[0];
    assign d1_o  = win_q[1];
    assign d2_o  = win_q[2];
    assign d3_o  = win_q[3];
    assign d4_o  = win_q[4];
    assign d5_o  = win_q[5];
    assign d6_o  = win_q[6];
    assign d7_o  = win_q[7];
    assign d8_o  = win_q[8];

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: RAM + calc models, table-driven frames,
// randomized frames, and hand-written reset / mid-frame start sequences.
module tb_sobel_frame_ctrl;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 12;
    localparam int TO = 16;
    localparam int N  = W * H;
    localparam int NI = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          busy_o, frame_done_o, err_o;
    logic          rd_en_o, wr_en_o, calc_start_o;
    logic [AW-1:0] rd_addr_o, wr_addr_o;
    logic [7:0]    rd_data_i, wr_data_o, calc_gray_i;
    logic          calc_done_i;
    logic [7:0]    d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;

    always #5 clk = ~clk;

    sobel_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .d0_o(d0_o), .d1_o(d1_o), .d2_o(d2_o), .d3_o(d3_o), .d4_o(d4_o),
        .d5_o(d5_o), .d6_o(d6_o), .d7_o(d7_o), .d8_o(d8_o),
        .calc_start_o(calc_start_o), .calc_gray_i(calc_gray_i),
        .calc_done_i(calc_done_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    logic [7:0] img [N];
    logic [7:0] outm [N];
    bit         written [N];
    int         wr_cyc [N];
    int         cyc = 0;
    int         c0 = 0;
    int         wr_cnt = 0;
    int         fd_cnt = 0;
    int         rd_cyc[$], rd_adr[$], st_log[$], lat_q[$];
    int         lat_mode = 3;
    int         rem = 0;
    logic [7:0] g_pend = '0;
    logic       all_or;

    assign all_or = |{busy_o, frame_done_o, err_o, rd_en_o, rd_addr_o,
                      wr_en_o, wr_addr_o, wr_data_o, calc_start_o,
                      d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o};

    // Order-sensitive window signature used as the calc result.
    function automatic int wsum(input logic [7:0] w [9]);
        int s = 0;
        for (int k = 0; k < 9; k++) s += int'(w[k]) * (k + 1);
        return s & 255;
    endfunction

    function automatic int win_exp(input int x, input int y);
        logic [7:0] w [9];
        for (int k = 0; k < 9; k++)
            w[k] = img[(y - 1 + k / 3) * W + (x - 1 + k % 3)];
        return wsum(w);
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) if (rd_en_o) rd_data_i <= img[rd_addr_o % N];

    // Calc model: answers L cycles after calc_start_o (L=0: never answers).
    always @(posedge clk) begin
        int l;
        logic [7:0] wv [9];
        calc_done_i <= 1'b0;
        calc_gray_i <= 8'($urandom);
        if (calc_start_o) begin
            l = (lat_mode < 0) ? int'($urandom_range(0, 8)) : lat_mode;
            lat_q.push_back(l);
            rem = l;
            wv = '{d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o};
            g_pend = 8'(wsum(wv));
        end
        if (rem == 1) begin
            calc_done_i <= 1'b1;
            calc_gray_i <= g_pend;
        end
        if (rem > 0) rem--;
    end

    always @(negedge clk) begin
        if (wr_en_o) begin
            wr_cnt++;
            if (int'(wr_addr_o) < N) begin
                outm[wr_addr_o]    = wr_data_o;
                written[wr_addr_o] = 1'b1;
                wr_cyc[wr_addr_o]  = cyc - c0;
            end
        end
        if (rd_en_o) begin
            rd_cyc.push_back(cyc - c0);
            rd_adr.push_back(int'(rd_addr_o));
        end
        if (calc_start_o) st_log.push_back(cyc - c0);
        if (frame_done_o) fd_cnt++;
    end

    task automatic fill_img(input int kind);
        for (int i = 0; i < N; i++)
            case (kind)
                0:       img[i] = 8'(i + 1);
                1:       img[i] = 8'($urandom);
                default: img[i] = 8'hFF;
            endcase
    endtask

    task automatic run_frame(input bit mid, input int exp_dc, input int exp_err,
                             input string tag);
        int dc, bb, ec, ee, li, l, e;
        dc = -1;
        bb = 0;
        lat_q.delete();
        rd_cyc.delete();
        rd_adr.delete();
        st_log.delete();
        wr_cnt = 0;
        fd_cnt = 0;
        for (int i = 0; i < N; i++) written[i] = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        c0 = cyc;
        for (int c = 1; c < 3000; c++) begin
            @(negedge clk);
            start_i = mid && (c == 20);
            if (frame_done_o) begin
                dc = c;
                if (busy_o) bb++;
                break;
            end
            if (!busy_o) bb++;
        end
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        ec = 1;
        ee = 0;
        li = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                if (x == 0 || y == 0 || x == W - 1 || y == H - 1) begin
                    e = 0;
                    ec += 1;
                end else begin
                    l = (li < lat_q.size()) ? lat_q[li] : 0;
                    li++;
                    if (l == 0) begin
                        e = 0;
                        ee = 1;
                        ec += 12 + TO;
                    end else begin
                        e = win_exp(x, y);
                        ec += 12 + l;
                    end
                end
                chk($sformatf("%s_px%0d", tag, y * W + x),
                    written[y * W + x] ? int'(outm[y * W + x]) : 256, e);
            end
        chk({tag, "_done_cycle"}, dc, ec);
        if (exp_dc >= 0) chk({tag, "_done_cycle_tbl"}, dc, exp_dc);
        chk({tag, "_err"}, int'(err_o), ee);
        if (exp_err >= 0) chk({tag, "_err_tbl"}, int'(err_o), exp_err);
        chk({tag, "_busy_shape"}, bb, 0);
        chk({tag, "_wr_count"}, wr_cnt, N);
        chk({tag, "_done_pulses"}, fd_cnt, 1);
        chk({tag, "_calc_starts"}, lat_q.size(), NI);
        chk({tag, "_idle_after"}, int'(busy_o | frame_done_o), 0);
    endtask

    typedef struct {
        int lat;
        int kind;
        int exp_dc;
        int exp_err;
    } vec_t;

    vec_t vecs [6];
    int   bz, wr0, fd0, rd0, n;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{lat: 3,  kind: 0, exp_dc: 73,  exp_err: 0};
        vecs[1] = '{lat: 1,  kind: 1, exp_dc: 65,  exp_err: 0};
        vecs[2] = '{lat: 0,  kind: 0, exp_dc: 125, exp_err: 1};
        vecs[3] = '{lat: 5,  kind: 2, exp_dc: 81,  exp_err: 0};
        vecs[4] = '{lat: 16, kind: 1, exp_dc: 125, exp_err: 0};
        vecs[5] = '{lat: -1, kind: 1, exp_dc: -1,  exp_err: -1};

        rst = 1'b1;
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", int'(all_or), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outs", int'(all_or), 0);

        for (int i = 0; i < 6; i++) begin
            lat_mode = vecs[i].lat;
            fill_img(vecs[i].kind);
            run_frame(1'b0, vecs[i].exp_dc, vecs[i].exp_err, $sformatf("vec%0d", i));
            if (i == 0) begin
                chk("rd_count", rd_adr.size(), 9 * NI);
                if (rd_adr.size() >= 9 && st_log.size() > 0) begin
                    for (int k = 0; k < 9; k++) begin
                        chk($sformatf("tap_addr%0d", k), rd_adr[k], (k / 3) * W + k % 3);
                        chk($sformatf("tap_cyc%0d", k), rd_cyc[k] - rd_cyc[0], k);
                    end
                    chk("issue_after_fetch", st_log[0] - rd_cyc[0], 10);
                end
            end
            if (i == 2 && st_log.size() > 0)
                chk("timeout_write_cyc", wr_cyc[W + 1] - st_log[0], TO + 1);
        end

        lat_mode = 2;
        fill_img(1);
        run_frame(1'b1, -1, 0, "midstart");

        for (int r = 0; r < 4; r++) begin
            lat_mode = -1;
            fill_img(1);
            run_frame(1'b0, -1, -1, $sformatf("rand%0d", r));
        end

        lat_mode = 5;
        st_log.delete();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (st_log.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reached_issue", int'(st_log.size() > 0), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_outs", int'(all_or), 0);
        rst = 1'b0;
        wr0 = wr_cnt;
        fd0 = fd_cnt;
        rd0 = rd_adr.size();
        bz = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy_o || wr_en_o || rd_en_o || frame_done_o) bz++;
        end
        chk("rst_quiet", bz, 0);
        chk("rst_no_writes", wr_cnt - wr0, 0);
        chk("rst_no_reads", rd_adr.size() - rd0, 0);
        chk("rst_no_done", fd_cnt - fd0, 0);

        lat_mode = 4;
        fill_img(0);
        run_frame(1'b0, 12 + NI * 16 + 1, 0, "recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
